sram_dp_wrapper: RTL and testbench

- Parametrised simple-dual-port SRAM wrapper for neuron-state and synapse memories in snn_ff.
- Has one write port with bit-granular write mask and one independent read port.
- Read latency is configurable, read-during-write behaviour is selectable, and a built-in clear engine sweeps the array to INIT_VAL after reset or on request.
- Behavioural array in simulation; maps to a dual-port SRAM macro or BRAM plus wrapper logic.

---
 rtl/sram_pkg.sv | 22 ++
 rtl/sram_dp_wrapper_if.sv | 30 +++
 rtl/sram_init_sweep.sv | 62 ++++++
 rtl/sram_dp_wrapper.sv | 123 ++++++++++++
 tb/tb_sram_dp_wrapper.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared constants for the simple-dual-port SRAM wrapper.
//   RDW_OLD / RDW_NEW  : read-during-write selection values for RDW_MODE
//   ST_IDLE / ST_CLEAR : 1-bit encoding of the clear-sweep FSM
//   READ_LATENCY_MIN/MAX, read_latency_ok() : legal read pipeline depths
package sram_pkg;

  localparam logic RDW_OLD = 1'b0;
  localparam logic RDW_NEW = 1'b1;

  typedef logic [0:0] sweep_state_t;

  localparam sweep_state_t ST_IDLE  = 1'b0;
  localparam sweep_state_t ST_CLEAR = 1'b1;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 2;

  function automatic bit read_latency_ok(input int lat);
    return (lat >= READ_LATENCY_MIN) && (lat <= READ_LATENCY_MAX);
  endfunction

endpackage

// File: rtl/sram_dp_wrapper_if.sv
// Request/response bundle of the dual-port SRAM wrapper.
//   master : drives CLR, WE, WA, D, WM, RE, RA; observes Q, QV, BUSY
//   slave  : the wrapper itself
interface sram_dp_wrapper_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) ();

  logic                  CLR;
  logic                  WE;
  logic [ADDR_WIDTH-1:0] WA;
  logic [DATA_WIDTH-1:0] D;
  logic [DATA_WIDTH-1:0] WM;
  logic                  RE;
  logic [ADDR_WIDTH-1:0] RA;
  logic [DATA_WIDTH-1:0] Q;
  logic                  QV;
  logic                  BUSY;

  modport master (
    output CLR, WE, WA, D, WM, RE, RA,
    input  Q, QV, BUSY
  );

  modport slave (
    input  CLR, WE, WA, D, WM, RE, RA,
    output Q, QV, BUSY
  );

endinterface

// File: rtl/sram_init_sweep.sv
// Clear-sweep engine: walks every word once, writing the init value.
//   CK, RSTN   : clock, async active-low reset
//   clr        : start request, honoured only while idle
//   busy       : sweep in progress (registered state)
//   sweep_we   : write strobe for the wrapper's write-port mux
//   sweep_addr : word currently being cleared
//
// state    | meaning
// ---------+----------------------------------------------
// ST_IDLE  | normal operation, user requests accepted
// ST_CLEAR | writing init value to sweep_addr, one per cycle
module sram_init_sweep
  import sram_pkg::*;
#(
  parameter int CNT_WIDTH    = 8,
  parameter int SRAM_DEPTH   = 256,
  parameter int CLR_ON_RESET = 1
) (
  input  logic                 CK,
  input  logic                 RSTN,
  input  logic                 clr,
  output logic                 busy,
  output logic                 sweep_we,
  output logic [CNT_WIDTH-1:0] sweep_addr
);

  localparam logic [CNT_WIDTH-1:0] LAST_ADDR = CNT_WIDTH'(SRAM_DEPTH - 1);
  localparam sweep_state_t RST_STATE = (CLR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  sweep_state_t         state;
  logic [CNT_WIDTH-1:0] clr_addr;

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= RST_STATE;
      clr_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
          end
        end
        default: begin
          // clr is deliberately ignored here: a running sweep never restarts
          if (clr_addr == LAST_ADDR) begin
            state    <= ST_IDLE;
            clr_addr <= '0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
      endcase
    end
  end

  assign busy       = (state == ST_CLEAR);
  assign sweep_we   = busy;
  assign sweep_addr = clr_addr;

endmodule

// File: rtl/sram_dp_wrapper.sv
// Simple-dual-port SRAM wrapper: one bit-masked write port, one read port,
// 1- or 2-cycle read latency, selectable read-during-write, clear sweep.
//   CK, RSTN : clock, async active-low reset
//   bus      : slave side of sram_dp_wrapper_if
//              CLR/WE/WA/D/WM/RE/RA requests, Q/QV read response, BUSY
module sram_dp_wrapper
  import sram_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 8,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    SRAM_DEPTH   = 256,
  parameter int                    READ_LATENCY = 1,
  parameter int                    RDW_MODE     = 1,
  parameter int                    CLR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL     = '0
) (
  input logic CK,
  input logic RSTN,
  sram_dp_wrapper_if.slave bus
);

  localparam int IDX_W = (SRAM_DEPTH > 1) ? $clog2(SRAM_DEPTH) : 1;
  // An illegal latency falls back to the shortest pipeline.
  localparam int LAT_EFF = read_latency_ok(READ_LATENCY) ? READ_LATENCY : READ_LATENCY_MIN;
  localparam bit USE_NEW = (RDW_MODE == int'(RDW_NEW));
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(SRAM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [SRAM_DEPTH];

  logic             busy;
  logic             sweep_we;
  logic [IDX_W-1:0] sweep_idx;

  sram_init_sweep #(
    .CNT_WIDTH    (IDX_W),
    .SRAM_DEPTH   (SRAM_DEPTH),
    .CLR_ON_RESET (CLR_ON_RESET)
  ) u_sweep (
    .CK         (CK),
    .RSTN       (RSTN),
    .clr        (bus.CLR),
    .busy       (busy),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_idx)
  );

  logic                  accept;
  logic                  wa_ok;
  logic                  ra_ok;
  logic                  wr_ok;
  logic                  rd_acc;
  logic [IDX_W-1:0]      wa_idx;
  logic [IDX_W-1:0]      ra_idx;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic [DATA_WIDTH-1:0] rd_word;

  assign accept    = ~busy;
  assign wa_ok     = ({1'b0, bus.WA} < DEPTH_EXT);
  assign ra_ok     = ({1'b0, bus.RA} < DEPTH_EXT);
  assign wa_idx    = bus.WA[IDX_W-1:0];
  assign ra_idx    = bus.RA[IDX_W-1:0];
  assign wr_ok     = accept & bus.WE & wa_ok;
  assign rd_acc    = accept & bus.RE;
  assign wr_merged = (mem[wa_idx] & ~bus.WM) | (bus.D & bus.WM);

  always_comb begin
    rd_word = INIT_VAL;
    if (ra_ok) begin
      if (USE_NEW && wr_ok && (bus.WA == bus.RA)) rd_word = wr_merged;
      else                                        rd_word = mem[ra_idx];
    end
  end

  // Sweep and user writes never coincide: user requests are dropped while busy.
  always_ff @(posedge CK) begin
    if (sweep_we)   mem[sweep_idx] <= INIT_VAL;
    else if (wr_ok) mem[wa_idx]    <= wr_merged;
  end

  logic                  fin_v;
  logic [DATA_WIDTH-1:0] fin_d;

  generate
    if (LAT_EFF == 2) begin : g_lat2
      logic                  s1_v;
      logic [DATA_WIDTH-1:0] s1_d;

      always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
          s1_v <= 1'b0;
          s1_d <= '0;
        end else begin
          s1_v <= rd_acc;
          if (rd_acc) s1_d <= rd_word;
        end
      end

      assign fin_v = s1_v;
      assign fin_d = s1_d;
    end else begin : g_lat1
      assign fin_v = rd_acc;
      assign fin_d = rd_word;
    end
  endgenerate

  logic [DATA_WIDTH-1:0] q_r;
  logic                  qv_r;

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      q_r  <= '0;
      qv_r <= 1'b0;
    end else begin
      qv_r <= fin_v;
      if (fin_v) q_r <= fin_d;
    end
  end

  assign bus.Q    = q_r;
  assign bus.QV   = qv_r;
  assign bus.BUSY = busy;

endmodule

// File: tb/tb_sram_dp_wrapper.sv
// Bench for sram_dp_wrapper: three configurations driven side by side and
// compared every cycle against a word-array reference model.
//   dut_a : depth 256, latency 1, new-data RDW, clear on reset, init 0
//   dut_b : depth 256, latency 2, old-data RDW, clear on reset, init A5A55A5A
//   dut_c : 9-bit address, depth 200, latency 1, new-data RDW, no reset clear
module tb_sram_dp_wrapper;

  localparam int NDUT = 3;
  localparam logic [31:0] INIT_A = 32'h0000_0000;
  localparam logic [31:0] INIT_B = 32'hA5A5_5A5A;
  localparam logic [31:0] INIT_C = 32'h0BAD_F00D;

  logic ck   = 1'b0;
  logic rstn = 1'b0;
  always #5 ck = ~ck;

  logic        clr [NDUT];
  logic        we  [NDUT];
  logic        re  [NDUT];
  logic [8:0]  wa  [NDUT];
  logic [8:0]  ra  [NDUT];
  logic [31:0] d   [NDUT];
  logic [31:0] wm  [NDUT];

  logic [31:0] o_q    [NDUT];
  logic        o_qv   [NDUT];
  logic        o_busy [NDUT];

  sram_dp_wrapper_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) if_a ();
  sram_dp_wrapper_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) if_b ();
  sram_dp_wrapper_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) if_c ();

  assign if_a.CLR = clr[0]; assign if_a.WE = we[0]; assign if_a.RE = re[0];
  assign if_a.WA = wa[0][7:0]; assign if_a.RA = ra[0][7:0];
  assign if_a.D = d[0]; assign if_a.WM = wm[0];
  assign if_b.CLR = clr[1]; assign if_b.WE = we[1]; assign if_b.RE = re[1];
  assign if_b.WA = wa[1][7:0]; assign if_b.RA = ra[1][7:0];
  assign if_b.D = d[1]; assign if_b.WM = wm[1];
  assign if_c.CLR = clr[2]; assign if_c.WE = we[2]; assign if_c.RE = re[2];
  assign if_c.WA = wa[2]; assign if_c.RA = ra[2];
  assign if_c.D = d[2]; assign if_c.WM = wm[2];

  assign o_q[0] = if_a.Q; assign o_qv[0] = if_a.QV; assign o_busy[0] = if_a.BUSY;
  assign o_q[1] = if_b.Q; assign o_qv[1] = if_b.QV; assign o_busy[1] = if_b.BUSY;
  assign o_q[2] = if_c.Q; assign o_qv[2] = if_c.QV; assign o_busy[2] = if_c.BUSY;

  sram_dp_wrapper #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .SRAM_DEPTH(256), .READ_LATENCY(1),
    .RDW_MODE(1), .CLR_ON_RESET(1), .INIT_VAL(INIT_A)
  ) dut_a (.CK(ck), .RSTN(rstn), .bus(if_a));

  sram_dp_wrapper #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .SRAM_DEPTH(256), .READ_LATENCY(2),
    .RDW_MODE(0), .CLR_ON_RESET(1), .INIT_VAL(INIT_B)
  ) dut_b (.CK(ck), .RSTN(rstn), .bus(if_b));

  sram_dp_wrapper #(
    .ADDR_WIDTH(9), .DATA_WIDTH(32), .SRAM_DEPTH(200), .READ_LATENCY(1),
    .RDW_MODE(1), .CLR_ON_RESET(0), .INIT_VAL(INIT_C)
  ) dut_c (.CK(ck), .RSTN(rstn), .bus(if_c));

  // configuration as seen by the model
  int          p_depth [NDUT] = '{256, 256, 200};
  int          p_lat   [NDUT] = '{1, 2, 1};
  bit          p_new   [NDUT] = '{1'b1, 1'b0, 1'b1};
  bit          p_cor   [NDUT] = '{1'b1, 1'b1, 1'b0};
  logic [31:0] p_init  [NDUT] = '{INIT_A, INIT_B, INIT_C};

  // reference model: word array, remaining sweep cycles, delayed read result
  logic [31:0] m_mem   [NDUT][512];
  bit          m_known [NDUT][512];
  int          m_busy  [NDUT];
  int          m_sidx  [NDUT];
  bit          m_s1v   [NDUT];
  logic [31:0] m_s1d   [NDUT];
  bit          m_s1k   [NDUT];
  logic [31:0] m_q     [NDUT];
  bit          m_qk    [NDUT];
  bit          m_qv    [NDUT];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] dv,
                                        input logic [31:0] mv);
    return (old_w & ~mv) | (dv & mv);
  endfunction

  task automatic model_reset(input int k);
    m_busy[k] = p_cor[k] ? p_depth[k] : 0;
    m_sidx[k] = 0;
    m_s1v[k]  = 1'b0;
    m_s1k[k]  = 1'b1;
    m_s1d[k]  = '0;
    m_q[k]    = '0;
    m_qk[k]   = 1'b1;
    m_qv[k]   = 1'b0;
  endtask

  task automatic model_edge(input int k);
    logic [31:0] rw, fd, mrg;
    bit acc_r, rk, fv, fk, wr_in, full;
    int wi, ri;
    rw = '0; rk = 1'b0; acc_r = 1'b0;
    wi = int'(wa[k]);
    ri = int'(ra[k]);
    if (m_busy[k] > 0) begin
      m_mem[k][m_sidx[k]]   = p_init[k];
      m_known[k][m_sidx[k]] = 1'b1;
      m_sidx[k]++;
      m_busy[k]--;
    end else begin
      wr_in = we[k] && (wi < p_depth[k]);
      full  = (wm[k] == 32'hFFFF_FFFF);
      mrg   = merge(m_mem[k][wi], d[k], wm[k]);
      if (re[k]) begin
        acc_r = 1'b1;
        if (ri >= p_depth[k]) begin
          rw = p_init[k]; rk = 1'b1;
        end else if (wr_in && wi == ri && p_new[k]) begin
          rw = mrg; rk = m_known[k][wi] || full;
        end else begin
          rw = m_mem[k][ri]; rk = m_known[k][ri];
        end
      end
      if (wr_in) begin
        m_mem[k][wi]   = mrg;
        m_known[k][wi] = m_known[k][wi] || full;
      end
      if (clr[k]) begin
        m_busy[k] = p_depth[k];
        m_sidx[k] = 0;
      end
    end
    if (p_lat[k] == 1) begin
      fv = acc_r; fd = rw; fk = rk;
    end else begin
      fv = m_s1v[k]; fd = m_s1d[k]; fk = m_s1k[k];
    end
    m_s1v[k] = acc_r; m_s1d[k] = rw; m_s1k[k] = rk;
    m_qv[k] = fv;
    if (fv) begin
      m_q[k]  = fd;
      m_qk[k] = fk;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NDUT; k++) begin
      check_val($sformatf("busy%0d", k), 32'(o_busy[k]), 32'(m_busy[k] > 0));
      check_val($sformatf("qv%0d", k), 32'(o_qv[k]), 32'(m_qv[k]));
      if (m_qk[k]) check_val($sformatf("q%0d", k), o_q[k], m_q[k]);
    end
  endtask

  task automatic step();
    @(posedge ck);
    for (int k = 0; k < NDUT; k++) model_edge(k);
    @(negedge ck);
    check_all();
  endtask

  task automatic idle_all();
    for (int k = 0; k < NDUT; k++) begin
      clr[k] = 1'b0; we[k] = 1'b0; re[k] = 1'b0;
      wa[k] = '0; ra[k] = '0; d[k] = '0; wm[k] = '0;
    end
  endtask

  task automatic wr_all(input logic [8:0] a, input logic [31:0] dv, input logic [31:0] mv);
    for (int k = 0; k < NDUT; k++) begin
      we[k] = 1'b1; wa[k] = a; d[k] = dv; wm[k] = mv;
    end
  endtask

  task automatic rd_all(input logic [8:0] a);
    for (int k = 0; k < NDUT; k++) begin
      re[k] = 1'b1; ra[k] = a;
    end
  endtask

  task automatic do_reset(input int cycles);
    rstn = 1'b0;
    for (int k = 0; k < NDUT; k++) model_reset(k);
    #1;
    check_all();
    for (int k = 0; k < NDUT; k++) begin
      check_val($sformatf("rst_q%0d", k), o_q[k], 32'h0);
      check_val($sformatf("rst_qv%0d", k), 32'(o_qv[k]), 32'h0);
    end
    repeat (cycles) begin
      @(negedge ck);
      check_all();
    end
    rstn = 1'b1;
  endtask

  // counts negedge samples with dut_a BUSY high, starting at the current point
  task automatic busy_run(input int limit, output int cnt);
    cnt = 0;
    for (int i = 0; i < limit; i++) begin
      if (o_busy[0]) cnt++;
      step();
    end
  endtask

  logic [31:0] vals [8];
  int cnt;

  initial begin
    idle_all();
    @(negedge ck);
    do_reset(3);

    // power-on sweep on a/b; manual clear of c in parallel
    clr[2] = 1'b1;
    step();
    clr[2] = 1'b0;
    check_val("busy_c_clr", 32'(o_busy[2]), 32'h1);
    cnt = 1;
    busy_run(299, cnt);
    // first sample was taken before the extra step above
    check_val("por_busy_len", 32'(cnt + 1), 32'd256);

    foreach (vals[i]) vals[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;

    // post-sweep reads return the init value one cycle later
    for (int i = 0; i < 3; i++) begin
      idle_all();
      rd_all(9'(i * 128 - (i == 2 ? 1 : 0)));
      step();
      check_val("clr_rd_q", o_q[0], INIT_A);
      check_val("clr_rd_qv", 32'(o_qv[0]), 32'h1);
    end

    // bit-masked write merge
    idle_all(); wr_all(9'd5, 32'hDEAD_BEEF, 32'hFFFF_FFFF); step();
    idle_all(); wr_all(9'd5, 32'h1234_5678, 32'h0000_FFFF); step();
    idle_all(); rd_all(9'd5); step();
    check_val("wm_merge_a", o_q[0], 32'hDEAD_5678);
    check_val("wm_merge_qv", 32'(o_qv[0]), 32'h1);
    idle_all(); step();
    check_val("wm_merge_b", o_q[1], 32'hDEAD_5678);
    check_val("wm_qv_drop", 32'(o_qv[0]), 32'h0);

    // read during write
    idle_all(); wr_all(9'd9, 32'h1111_1111, 32'hFFFF_FFFF); step();
    idle_all(); wr_all(9'd9, 32'h2222_2222, 32'hFFFF_FFFF); rd_all(9'd9); step();
    check_val("rdw_new_a", o_q[0], 32'h2222_2222);
    idle_all(); rd_all(9'd9); step();
    check_val("rdw_old_b", o_q[1], 32'h1111_1111);
    check_val("rdw_after_a", o_q[0], 32'h2222_2222);
    idle_all(); step();
    check_val("rdw_after_b", o_q[1], 32'h2222_2222);

    // latency-2 streaming reads
    for (int i = 0; i < 8; i++) begin
      idle_all(); wr_all(9'(i), vals[i], 32'hFFFF_FFFF); step();
    end
    for (int i = 0; i < 8; i++) begin
      idle_all(); rd_all(9'(i)); step();
      if (i == 0) begin
        check_val("l2_first_qv", 32'(o_qv[1]), 32'h0);
      end else begin
        check_val("l2_stream_qv", 32'(o_qv[1]), 32'h1);
        check_val("l2_stream_q", o_q[1], vals[i-1]);
      end
    end
    idle_all(); step();
    check_val("l2_last_q", o_q[1], vals[7]);
    check_val("l2_last_qv", 32'(o_qv[1]), 32'h1);
    idle_all(); step();
    check_val("l2_end_qv", 32'(o_qv[1]), 32'h0);

    // clear sweep with requests held high
    idle_all();
    for (int k = 0; k < NDUT; k++) clr[k] = 1'b1;
    step();
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < NDUT; k++) begin
        clr[k] = 1'b1;
        we[k] = 1'b1; re[k] = 1'b1;
        wa[k] = 9'($urandom_range(0, 255)); ra[k] = 9'($urandom_range(0, 255));
        d[k] = $urandom; wm[k] = 32'hFFFF_FFFF;
      end
      step();
      if (o_qv[0]) cnt++;
    end
    check_val("sweep_qv_cnt", 32'(cnt), 32'h0);
    for (int a = 0; a < 256; a++) begin
      idle_all(); rd_all(9'(a)); step();
      check_val("sweep_clean_a", o_q[0], INIT_A);
    end

    // reset in the middle of a sweep
    idle_all();
    for (int k = 0; k < NDUT; k++) clr[k] = 1'b1;
    step();
    idle_all();
    repeat (100) step();
    do_reset(3);
    busy_run(300, cnt);
    check_val("rst_busy_len", 32'(cnt), 32'd256);

    // out-of-range read on the 200-word instance
    idle_all();
    re[2] = 1'b1; ra[2] = 9'h100;
    step();
    check_val("oor_q", o_q[2], INIT_C);
    check_val("oor_qv", 32'(o_qv[2]), 32'h1);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      for (int k = 0; k < NDUT; k++) begin
        int amax;
        int sel;
        amax   = (k == 2) ? 511 : 255;
        clr[k] = ($urandom_range(0, 299) == 0);
        we[k]  = $urandom_range(0, 1) == 1;
        re[k]  = $urandom_range(0, 1) == 1;
        wa[k]  = 9'($urandom_range(0, amax));
        ra[k]  = ($urandom_range(0, 3) == 0) ? wa[k] : 9'($urandom_range(0, amax));
        d[k]   = $urandom;
        sel    = $urandom_range(0, 3);
        wm[k]  = (sel == 0) ? 32'h0 : (sel == 1) ? 32'hFFFF_FFFF : $urandom;
      end
      step();
    end

    idle_all();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
